// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and default widths for the timer subsystem
package timer_pkg;

    localparam int TIMER_BITS_WIDTH = 32;
    localparam int TIMER_FILT_WIDTH = 4;
    localparam int IC_EVT_WIDTH     = 3;

    typedef enum logic [1:0] {
        IC_RISE = 2'b00,
        IC_FALL = 2'b01,
        IC_BOTH = 2'b10
    } ic_pol_t;

    typedef enum logic [1:0] {
        IC_DISABLED = 2'b00,
        IC_SEED     = 2'b01,
        IC_ACTIVE   = 2'b10
    } ic_state_t;

    // Terminal event count for a prescaler code: capture every 1/2/4/8 edges
    function automatic logic [IC_EVT_WIDTH-1:0] ic_psc_limit(input logic [1:0] psc);
        logic [IC_EVT_WIDTH-1:0] lim;
        case (psc)
            2'd0:    lim = 3'd0;
            2'd1:    lim = 3'd1;
            2'd2:    lim = 3'd3;
            default: lim = 3'd7;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/ic_sync_filter.sv
// rtl/ic_sync_filter.sv - pin synchroniser, glitch filter and filtered-edge detector
module ic_sync_filter
    import timer_pkg::*;
#(
    parameter int FILT_WIDTH = TIMER_FILT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pin_in,
    input  logic                  run,
    input  logic                  seed,
    input  logic                  clr,
    input  logic [FILT_WIDTH-1:0] filt_len,
    output logic                  level,
    output logic                  rise,
    output logic                  fall
);

    logic                  s1_q, s1_d;
    logic                  s2_q, s2_d;
    logic                  f_q, f_d;
    logic [FILT_WIDTH-1:0] cnt_q, cnt_d;
    logic                  change;

    // Next-state for synchroniser (always running) and the filter (gated by run)
    always_comb begin
        s1_d   = pin_in;
        s2_d   = s1_q;
        f_d    = f_q;
        cnt_d  = cnt_q;
        change = 1'b0;
        if (seed) begin
            // Adopt the current pin level silently so a level present at enable is not an edge
            f_d   = s2_q;
            cnt_d = '0;
        end else if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            if (s2_q == f_q) begin
                cnt_d = '0;
            end else if (cnt_q == filt_len) begin
                f_d    = s2_q;
                cnt_d  = '0;
                change = 1'b1;
            end else begin
                cnt_d = cnt_q + FILT_WIDTH'(1);
            end
        end
    end

    // Synchroniser, filtered level and filter counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            f_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            f_q   <= f_d;
            cnt_q <= cnt_d;
        end
    end

    assign level = f_q;
    assign rise  = change & s2_q;
    assign fall  = change & ~s2_q;

endmodule

// File: rtl/timer_input_capture.sv
// rtl/timer_input_capture.sv - input-capture channel: FSM, event prescaler, capture register, flags
module timer_input_capture
    import timer_pkg::*;
#(
    parameter int BITS_WIDTH = TIMER_BITS_WIDTH,
    parameter int FILT_WIDTH = TIMER_FILT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ic_en,
    input  logic                  tc_rst,
    input  logic [1:0]            ic_pol,
    input  logic [1:0]            ic_psc,
    input  logic [FILT_WIDTH-1:0] ic_filt,
    input  logic                  ic_irq_en,
    input  logic                  clr_flag,
    input  logic                  cap_in,
    input  logic [BITS_WIDTH-1:0] tcnt,
    output logic [BITS_WIDTH-1:0] ccr,
    output logic                  cap_flag,
    output logic                  over_flag,
    output logic                  ic_irq
);

    ic_state_t                 state_q, state_d;
    logic [IC_EVT_WIDTH-1:0]   evt_q, evt_d;
    logic [BITS_WIDTH-1:0]     ccr_q, ccr_d;
    logic                      cap_flag_q, cap_flag_d;
    logic                      over_flag_q, over_flag_d;
    logic                      irq_q, irq_d;

    logic filt_level;
    logic filt_rise;
    logic filt_fall;
    logic edge_hit;
    logic capture;

    ic_sync_filter #(
        .FILT_WIDTH (FILT_WIDTH)
    ) u_sync_filter (
        .clk      (clk),
        .rst      (rst),
        .pin_in   (cap_in),
        .run      ((state_q == IC_ACTIVE) && !tc_rst),
        .seed     (state_q == IC_SEED),
        .clr      (tc_rst),
        .filt_len (ic_filt),
        .level    (filt_level),
        .rise     (filt_rise),
        .fall     (filt_fall)
    );

    // Channel FSM, edge qualification, prescaler, capture and flag next-state
    always_comb begin
        state_d     = state_q;
        evt_d       = evt_q;
        ccr_d       = ccr_q;
        cap_flag_d  = cap_flag_q;
        over_flag_d = over_flag_q;
        capture     = 1'b0;

        // A pulse only counts against the level it leaves behind
        case (ic_pol)
            IC_RISE: edge_hit = filt_rise & ~filt_level;
            IC_FALL: edge_hit = filt_fall & filt_level;
            default: edge_hit = (filt_rise & ~filt_level) | (filt_fall & filt_level);
        endcase

        case (state_q)
            IC_DISABLED: if (ic_en) state_d = IC_SEED;
            IC_SEED:     state_d = IC_ACTIVE;
            IC_ACTIVE:   if (!ic_en) state_d = IC_DISABLED;
            default:     state_d = IC_DISABLED;
        endcase

        if (tc_rst || state_q == IC_SEED) begin
            evt_d = '0;
        end else if (edge_hit) begin
            // >= so a prescaler lowered mid-count captures at once instead of wrapping
            if (evt_q >= ic_psc_limit(ic_psc)) begin
                capture = 1'b1;
                evt_d   = '0;
            end else begin
                evt_d = evt_q + IC_EVT_WIDTH'(1);
            end
        end

        if (tc_rst) begin
            state_d     = ic_en ? IC_SEED : IC_DISABLED;
            ccr_d       = '0;
            cap_flag_d  = 1'b0;
            over_flag_d = 1'b0;
        end else if (capture) begin
            ccr_d = tcnt;
            if (clr_flag) begin
                cap_flag_d  = 1'b1;
                over_flag_d = 1'b0;
            end else if (cap_flag_q) begin
                over_flag_d = 1'b1;
            end else begin
                cap_flag_d = 1'b1;
            end
        end else if (clr_flag) begin
            cap_flag_d  = 1'b0;
            over_flag_d = 1'b0;
        end

        irq_d = cap_flag_d & ic_irq_en;
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IC_DISABLED;
            evt_q       <= '0;
            ccr_q       <= '0;
            cap_flag_q  <= 1'b0;
            over_flag_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            evt_q       <= evt_d;
            ccr_q       <= ccr_d;
            cap_flag_q  <= cap_flag_d;
            over_flag_q <= over_flag_d;
            irq_q       <= irq_d;
        end
    end

    assign ccr       = ccr_q;
    assign cap_flag  = cap_flag_q;
    assign over_flag = over_flag_q;
    assign ic_irq    = irq_q;

endmodule

// File: tb/tb_timer_input_capture.sv
// tb/tb_timer_input_capture.sv - directed self-checking bench for timer_input_capture
module tb_timer_input_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_en;
    logic        tc_rst;
    logic [1:0]  ic_pol;
    logic [1:0]  ic_psc;
    logic [3:0]  ic_filt;
    logic        ic_irq_en;
    logic        clr_flag;
    logic        cap_in;
    logic [31:0] tcnt;
    logic [31:0] ccr;
    logic        cap_flag;
    logic        over_flag;
    logic        ic_irq;

    int n_checks = 0;
    int n_pass   = 0;

    timer_input_capture dut (
        .clk       (clk),
        .rst       (rst),
        .ic_en     (ic_en),
        .tc_rst    (tc_rst),
        .ic_pol    (ic_pol),
        .ic_psc    (ic_psc),
        .ic_filt   (ic_filt),
        .ic_irq_en (ic_irq_en),
        .clr_flag  (clr_flag),
        .cap_in    (cap_in),
        .tcnt      (tcnt),
        .ccr       (ccr),
        .cap_flag  (cap_flag),
        .over_flag (over_flag),
        .ic_irq    (ic_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock; inputs change 1 time unit after the edge, time base advances by one
    task automatic step();
        @(posedge clk);
        #1;
        tcnt = tcnt + 32'd1;
    endtask

    initial begin
        rst = 1'b1; ic_en = 1'b0; tc_rst = 1'b0; ic_pol = 2'b00; ic_psc = 2'b00;
        ic_filt = 4'd0; ic_irq_en = 1'b0; clr_flag = 1'b0; cap_in = 1'b0; tcnt = 32'd0;
        #2;
        check("rst_ccr", ccr, 0);
        check("rst_cap", 32'(cap_flag), 0);
        check("rst_over", 32'(over_flag), 0);
        check("rst_irq", 32'(ic_irq), 0);
        step(); step();
        rst = 1'b0;

        // Unfiltered rising capture: two sync stages then capture
        ic_en = 1'b1;
        repeat (4) step();
        tcnt = 32'd100; cap_in = 1'b1;
        step(); step();
        check("t1_not_yet", 32'(cap_flag), 0);
        step();
        check("t1_ccr", ccr, 102);
        check("t1_cap", 32'(cap_flag), 1);
        check("t1_over", 32'(over_flag), 0);
        check("t1_irq_off", 32'(ic_irq), 0);
        clr_flag = 1'b1; step(); clr_flag = 1'b0;
        check("t1_clr_cap", 32'(cap_flag), 0);
        check("t1_ccr_kept", ccr, 102);

        // Filter of 3: a 3-cycle pulse is rejected, a 5-cycle pulse captures 3 cycles late
        ic_filt = 4'd3; cap_in = 1'b0;
        repeat (8) step();
        check("t2_settle", 32'(cap_flag), 0);
        cap_in = 1'b1; repeat (3) step(); cap_in = 1'b0;
        repeat (8) step();
        check("t2_short_pulse", 32'(cap_flag), 0);
        tcnt = 32'd200; cap_in = 1'b1;
        repeat (5) step();
        check("t2_not_yet", 32'(cap_flag), 0);
        cap_in = 1'b0; step();
        check("t2_ccr", ccr, 205);
        check("t2_cap", 32'(cap_flag), 1);
        clr_flag = 1'b1; step(); clr_flag = 1'b0;
        repeat (8) step();
        check("t2_fall_ignored", 32'(cap_flag), 0);

        // Both edges, capture every 2nd edge
        ic_filt = 4'd0; ic_pol = 2'b10; ic_psc = 2'b01;
        cap_in = 1'b1; repeat (4) step();
        check("t3_edge1", 32'(cap_flag), 0);
        tcnt = 32'd300; cap_in = 1'b0; repeat (3) step();
        check("t3_edge2_ccr", ccr, 302);
        check("t3_edge2_cap", 32'(cap_flag), 1);
        step();
        clr_flag = 1'b1; step(); clr_flag = 1'b0;
        cap_in = 1'b1; repeat (4) step();
        check("t3_edge3", 32'(cap_flag), 0);
        tcnt = 32'd400; cap_in = 1'b0; repeat (3) step();
        check("t3_edge4_ccr", ccr, 402);
        check("t3_edge4_cap", 32'(cap_flag), 1);
        check("t3_edge4_over", 32'(over_flag), 0);

        // Overcapture, capture with acknowledge, acknowledge alone
        ic_pol = 2'b00; ic_psc = 2'b00; step();
        tcnt = 32'd500; cap_in = 1'b1; repeat (3) step();
        check("t4_ccr", ccr, 502);
        check("t4_over", 32'(over_flag), 1);
        check("t4_cap", 32'(cap_flag), 1);
        cap_in = 1'b0; repeat (4) step();
        tcnt = 32'd600; cap_in = 1'b1; step(); step();
        clr_flag = 1'b1; step(); clr_flag = 1'b0;
        check("t4_clrcap_ccr", ccr, 602);
        check("t4_clrcap_cap", 32'(cap_flag), 1);
        check("t4_clrcap_over", 32'(over_flag), 0);
        clr_flag = 1'b1; step(); clr_flag = 1'b0;
        check("t4_clr_cap", 32'(cap_flag), 0);
        check("t4_clr_over", 32'(over_flag), 0);

        // Pin rises while disabled; enabling must not report it
        cap_in = 1'b0; repeat (4) step();
        ic_en = 1'b0; step();
        cap_in = 1'b1; repeat (5) step();
        check("t5_disabled", 32'(cap_flag), 0);
        ic_en = 1'b1; repeat (6) step();
        check("t5_seed_suppress", 32'(cap_flag), 0);
        check("t5_ccr_kept", ccr, 602);
        ic_irq_en = 1'b1; cap_in = 1'b0; repeat (4) step();
        tcnt = 32'd700; cap_in = 1'b1; step(); step();
        check("t5_irq_pre", 32'(ic_irq), 0);
        step();
        check("t5_cap", 32'(cap_flag), 1);
        check("t5_irq", 32'(ic_irq), 1);
        check("t5_ccr", ccr, 702);
        ic_irq_en = 1'b0; step();
        check("t5_irq_drop", 32'(ic_irq), 0);
        check("t5_cap_hold", 32'(cap_flag), 1);

        // Channel clear coincident with a capture discards it and re-seeds
        clr_flag = 1'b1; step(); clr_flag = 1'b0;
        cap_in = 1'b0; repeat (4) step();
        tcnt = 32'd800; cap_in = 1'b1; step(); step();
        tc_rst = 1'b1; step(); tc_rst = 1'b0;
        check("t6_tcrst_ccr", ccr, 0);
        check("t6_tcrst_cap", 32'(cap_flag), 0);
        check("t6_tcrst_over", 32'(over_flag), 0);
        repeat (6) step();
        check("t6_reseed", 32'(cap_flag), 0);
        ic_irq_en = 1'b1; cap_in = 1'b0; repeat (4) step();
        tcnt = 32'd900; cap_in = 1'b1; repeat (3) step();
        check("t6_after_ccr", ccr, 902);
        check("t6_after_cap", 32'(cap_flag), 1);
        check("t6_after_irq", 32'(ic_irq), 1);

        // Asynchronous reset in the middle of a filter run
        ic_filt = 4'd3; cap_in = 1'b0; repeat (3) step();
        rst = 1'b1; #1;
        check("t7_rst_ccr", ccr, 0);
        check("t7_rst_cap", 32'(cap_flag), 0);
        check("t7_rst_over", 32'(over_flag), 0);
        check("t7_rst_irq", 32'(ic_irq), 0);
        step(); rst = 1'b0;
        repeat (8) step();
        check("t7_post_cap", 32'(cap_flag), 0);
        check("t7_post_ccr", ccr, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_input_capture.md
Name: timer_input_capture

Overview:
- One input-capture channel for the timer subsystem. Samples an asynchronous external pin and detects the selected edge after synchronisation and glitch filtering.
- On every Nth qualifying edge, latches the time-base count into a capture register.
- Raises a capture flag, an overcapture flag and an interrupt.
- Sits beside the time base and consumes its tcnt bus; it is the measuring end of the timer, where the time base is the generating end.

Parameters:
BITS_WIDTH, 32, width of tcnt and ccr
FILT_WIDTH, 4, width of the filter-length field and the filter counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
ic_en  input  1  channel enable
tc_rst  input  1  synchronous channel clear (same cycle as time-base reset)
ic_pol  input  2  edge select: 00 rising, 01 falling, 10/11 both
ic_psc  input  2  event prescaler: capture every 1/2/4/8 qualifying edges
ic_filt  input  FILT_WIDTH  consecutive stable cycles required before a level change is accepted
ic_irq_en  input  1  interrupt enable
clr_flag  input  1  one-cycle pulse: acknowledge cap_flag/over_flag
cap_in  input  1  asynchronous external capture pin
tcnt  input  BITS_WIDTH  current time-base count
ccr  output  BITS_WIDTH  captured count
cap_flag  output  1  capture occurred since last acknowledge
over_flag  output  1  capture occurred while cap_flag already set
ic_irq  output  1  interrupt request

Behaviour:
- Reset (rst=1, async): ccr=0, cap_flag=0, over_flag=0, ic_irq=0, sync flops=0, filtered level=0, filter count=0, event count=0, FSM=DISABLED.
- Sync: 2-flop synchroniser s1->s2 on cap_in, always running, including while disabled.
- Filter:
  - Counter counts consecutive cycles with s2 != filtered level f; clears whenever s2 == f.
  - When s2 != f and count == ic_filt, f <= s2 and count <= 0. ic_filt=0 means f follows s2 with one register delay.
- Edge: qualifying when f changes this cycle in the polarity selected by ic_pol.
- FSM:
  - DISABLED: filter and event logic frozen; ccr and flags retained. ic_en=1 -> SEED.
  - SEED (one cycle): f <= s2, filter count <= 0, event count <= 0, no edge generated. -> ACTIVE. A pin already high at enable is never reported as an edge.
  - ACTIVE: ic_en=0 -> DISABLED on next clock. An edge in the same cycle as the disable is still processed.
- Event prescaler:
  - On a qualifying edge, if event count == (2^ic_psc - 1): capture and event count <= 0.
  - Otherwise event count increments, with no capture.
- Capture: ccr <= tcnt as sampled in the cycle f updates; ccr is valid the cycle after.
- Latency, ic_filt=0, ic_psc=0: cap_in stable before clock edge k -> s1 at k, s2 at k+1, f and ccr at k+2. ic_filt=N adds N cycles.
- Flags, priority high to low:
  - tc_rst=1: ccr<=0, cap_flag<=0, over_flag<=0, filter/event counters<=0. If ic_en, FSM -> SEED; a capture in the same cycle is discarded.
  - capture with cap_flag=1 and clr_flag=0: over_flag<=1, cap_flag stays 1.
  - capture with clr_flag=1: cap_flag<=1, over_flag<=0.
  - clr_flag=1 without capture: both flags <=0.
  - Otherwise flags hold.
- ic_irq is registered: ic_irq <= next cap_flag & ic_irq_en. It rises in the same cycle as cap_flag, and clearing ic_irq_en drops ic_irq on the next clock.
- ic_pol or ic_psc changed while ACTIVE: the new value takes effect immediately; the event count is not reset.
- Wrap-around: ccr is the raw tcnt, with no rollover correction; software handles the period.

Decomposition:
- timer_pkg:
  - ic_pol_t enum (IC_RISE, IC_FALL, IC_BOTH)
  - ic_state_t enum (IC_DISABLED, IC_SEED, IC_ACTIVE)
  - default widths shared with the time base
- Sub-module ic_sync_filter: synchroniser, filter counter and filtered level. Outputs f plus rise/fall pulses. Reused by future trigger and external-clock inputs.
- Top level: FSM, event prescaler, capture register, flags.

Test Plan:
- Enable, ic_pol=00, ic_filt=0, ic_psc=0, tcnt incrementing from 100; raise cap_in before edge k -> ccr equals the tcnt value sampled at edge k+2; cap_flag=1; over_flag=0.
- ic_filt=3; pulse cap_in high for 3 cycles, then 5 cycles -> 3-cycle pulse gives no capture; 5-cycle pulse captures 3 cycles later than the unfiltered case.
- ic_pol=10, ic_psc=01 (every 2nd edge); drive 4 edges (rise, fall, rise, fall) -> exactly 2 captures, on the 2nd and 4th edges.
- Two captures with no clr_flag -> over_flag=1. Capture coincident with clr_flag -> cap_flag=1, over_flag=0. clr_flag alone -> both 0.
- cap_in held high, then ic_en 0->1 -> no capture, because SEED suppresses the edge. ic_irq_en=1 with a later rising edge -> ic_irq=1 together with cap_flag.
- Assert rst mid-filter and tc_rst coincident with a capture -> every output 0 immediately on rst; for tc_rst, no capture, flags 0, and the FSM re-seeds.
